// File: rtl/joint_ramp_ctrl.sv
// joint_ramp_ctrl: velocity-command sequencer in front of one stepgen.
// Accepts target step frequencies over a valid/ready handshake and slews
// jointFreqCmd toward the active target by at most ACCEL_STEP every
// ACCEL_DIV clocks. Disable or a command-watchdog expiry forces a ramp to
// zero; a watchdog stop ends in a latched fault that enable=0 clears.
//
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   enable        - run permission; low ramps to zero and clears a fault
//   target_freq   - signed target step frequency
//   target_valid  - target_freq is valid
//   target_ready  - a target is accepted this cycle if valid
//   jointFreqCmd  - signed frequency command to stepgen
//   at_target     - jointFreqCmd equals the effective target
//   wd_fault      - watchdog stop completed, fault latched
//   state         - 0=IDLE 1=RUN 2=STOPPING 3=FAULT
module joint_ramp_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ACCEL_DIV  = 16,
  parameter int unsigned ACCEL_STEP = 4,
  parameter int unsigned WATCHDOG   = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] target_freq,
  input  logic             target_valid,
  output logic             target_ready,
  output logic [WIDTH-1:0] jointFreqCmd,
  output logic             at_target,
  output logic             wd_fault,
  output logic [1:0]       state
);

  localparam int unsigned CW = $clog2(ACCEL_DIV + 1);
  localparam int unsigned WW = $clog2(WATCHDOG + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCEL_DIV - 1);
  localparam logic [WW-1:0] WD_MAX   = WW'(WATCHDOG);
  localparam logic signed [WIDTH:0] STEP_X = (WIDTH+1)'(ACCEL_STEP);
  localparam logic signed [WIDTH:0] MAX_X  = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0] MIN_X  = {2'b11, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2,
    S_FAULT    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] tgt_q, tgt_d;
  logic signed [WIDTH-1:0] freq_q, freq_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WW-1:0]           wd_q, wd_d;
  logic                    wd_cause_q, wd_cause_d;
  logic                    wd_fault_q, wd_fault_d;

  logic signed [WIDTH-1:0] eff;
  logic signed [WIDTH:0]   f_x, e_x, step_x;
  logic signed [WIDTH-1:0] ramped;
  logic                    accept, upd;

  always_comb begin
    target_ready = enable && !reset && (state_q == S_IDLE || state_q == S_RUN);
    accept       = target_valid && target_ready;
    eff          = (state_q == S_RUN) ? tgt_q : '0;

    // One ramp step computed one bit wider so the +/- step cannot wrap.
    f_x = {freq_q[WIDTH-1], freq_q};
    e_x = {eff[WIDTH-1], eff};
    if (f_x < e_x) begin
      step_x = f_x + STEP_X;
      if (step_x > e_x) step_x = e_x;
    end else if (f_x > e_x) begin
      step_x = f_x - STEP_X;
      if (step_x < e_x) step_x = e_x;
    end else begin
      step_x = f_x;
    end
    if (step_x > MAX_X) step_x = MAX_X;
    else if (step_x < MIN_X) step_x = MIN_X;

    // A step that would flip the sign lands on exactly zero, so stepgen
    // sees a full ramp period at zero before any direction change.
    if ((freq_q != '0) && (step_x != '0) && (step_x[WIDTH] != freq_q[WIDTH-1]))
      ramped = '0;
    else
      ramped = step_x[WIDTH-1:0];

    state_d    = state_q;
    tgt_d      = tgt_q;
    freq_d     = freq_q;
    cnt_d      = cnt_q;
    wd_d       = wd_q;
    wd_cause_d = wd_cause_q;

    if (accept) tgt_d = target_freq;

    upd = 1'b0;
    if (state_q == S_IDLE || state_q == S_FAULT) begin
      cnt_d  = '0;
      freq_d = '0;
    end else begin
      upd   = (cnt_q == CNT_LAST);
      cnt_d = upd ? '0 : cnt_q + CW'(1);
      if (upd) freq_d = ramped;
    end

    if (state_q != S_RUN || accept)
      wd_d = '0;
    else if ((freq_q != '0 || tgt_q != '0) && wd_q != WD_MAX)
      wd_d = wd_q + WW'(1);

    unique case (state_q)
      S_IDLE: if (accept) state_d = S_RUN;
      S_RUN: begin
        if (accept) begin
          state_d = S_RUN;
        end else if (!enable) begin
          state_d    = S_STOPPING;
          wd_cause_d = 1'b0;
        end else if (wd_q == WD_MAX) begin
          state_d    = S_STOPPING;
          wd_cause_d = 1'b1;
        end else if (tgt_q == '0 && freq_q == '0) begin
          state_d = S_IDLE;
        end
      end
      S_STOPPING: if (freq_q == '0) state_d = wd_cause_q ? S_FAULT : S_IDLE;
      S_FAULT:    if (!enable) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    wd_fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tgt_q      <= '0;
      freq_q     <= '0;
      cnt_q      <= '0;
      wd_q       <= '0;
      wd_cause_q <= 1'b0;
      wd_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      freq_q     <= freq_d;
      cnt_q      <= cnt_d;
      wd_q       <= wd_d;
      wd_cause_q <= wd_cause_d;
      wd_fault_q <= wd_fault_d;
    end
  end

  assign jointFreqCmd = freq_q;
  assign at_target    = (freq_q == eff);
  assign wd_fault     = wd_fault_q;
  assign state        = state_q;

endmodule

// File: tb/tb_joint_ramp_ctrl.sv
// Directed bench for joint_ramp_ctrl: a default-parameter instance for the
// ramp, stop, watchdog and reset behaviour, plus a large-step instance that
// drives jointFreqCmd to both signed limits.
module tb_joint_ramp_ctrl;

  logic        clk = 1'b0;
  logic        reset, enable, target_valid, target_ready, at_target, wd_fault;
  logic [31:0] target_freq, cmd;
  logic [1:0]  state;

  logic        b_reset, b_enable, b_valid, b_ready, b_at_target, b_wd_fault;
  logic [31:0] b_freq, b_cmd;
  logic [1:0]  b_state;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  joint_ramp_ctrl #(.WIDTH(32), .ACCEL_DIV(16), .ACCEL_STEP(4), .WATCHDOG(1000)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .target_freq(target_freq), .target_valid(target_valid), .target_ready(target_ready),
    .jointFreqCmd(cmd), .at_target(at_target), .wd_fault(wd_fault), .state(state)
  );

  joint_ramp_ctrl #(.WIDTH(32), .ACCEL_DIV(1), .ACCEL_STEP(32'h6000_0000), .WATCHDOG(1000)) dut_big (
    .clk(clk), .reset(b_reset), .enable(b_enable),
    .target_freq(b_freq), .target_valid(b_valid), .target_ready(b_ready),
    .jointFreqCmd(b_cmd), .at_target(b_at_target), .wd_fault(b_wd_fault), .state(b_state)
  );

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic accept(input logic [31:0] v);
    target_freq  = v;
    target_valid = 1'b1;
    tick(1);
    target_valid = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [1:0] exp, input int unsigned limit);
    int unsigned n;
    n = 0;
    while (state !== exp && n < limit) begin
      tick(1);
      n++;
    end
    check(tag, state, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int signed dn[12];
    dn = '{32, 28, 24, 20, 16, 12, 8, 4, 0, -4, -8, -10};

    reset = 1'b1; enable = 1'b0; target_valid = 1'b0; target_freq = '0;
    b_reset = 1'b1; b_enable = 1'b0; b_valid = 1'b0; b_freq = '0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_cmd", $signed(cmd), 0);
    check("rst_state", state, 0);
    check("rst_at_target", at_target, 1);
    check("rst_wd_fault", wd_fault, 0);
    check("rst_ready", target_ready, 0);

    // Ramp up 0 -> 40, one step of 4 every 16 clocks.
    enable = 1'b1;
    #1;
    check("ready_idle", target_ready, 1);
    accept(40);
    check("up_state", state, 1);
    check("up_at_target0", at_target, 0);
    tick(15);
    check("up_before_first", $signed(cmd), 0);
    tick(1);
    check("up_1", $signed(cmd), 4);
    for (int k = 2; k <= 10; k++) begin
      tick(16);
      check("up_k", $signed(cmd), 4 * k);
    end
    check("up_at_target", at_target, 1);
    check("up_run", state, 1);

    // Reverse 40 -> -10 with a full ramp period parked at zero.
    accept(-10);
    tick(15);
    check("dn_first", $signed(cmd), 36);
    for (int i = 0; i < 12; i++) begin
      if (i > 0 && dn[i-1] == 0) begin
        tick(15);
        check("dn_zero_hold", $signed(cmd), 0);
        tick(1);
      end else begin
        tick(16);
      end
      check("dn_step", $signed(cmd), dn[i]);
    end
    check("dn_at_target", at_target, 1);
    check("dn_run", state, 1);

    // Disable stop: -10 ramps back to 0 with no fault, then IDLE.
    accept(10);
    enable = 1'b0;
    #1;
    check("dis_ready", target_ready, 0);
    tick(1);
    check("dis_stopping", state, 2);
    tick(14);
    check("dis_m6", $signed(cmd), -6);
    tick(16);
    check("dis_m2", $signed(cmd), -2);
    tick(16);
    check("dis_zero", $signed(cmd), 0);
    check("dis_still_stop", state, 2);
    check("dis_wd_fault", wd_fault, 0);
    tick(1);
    check("dis_idle", state, 0);
    check("dis_wd_fault2", wd_fault, 0);
    enable = 1'b1;
    #1;
    check("dis_ready_back", target_ready, 1);

    // Watchdog expiry: stop after exactly 1000 idle counts, then FAULT.
    accept(20);
    tick(1000);
    check("wd_last_run", state, 1);
    check("wd_cmd20", $signed(cmd), 20);
    tick(1);
    check("wd_stopping", state, 2);
    check("wd_no_fault_yet", wd_fault, 0);
    wait_state("wd_fault_state", 3, 200);
    check("wd_fault_flag", wd_fault, 1);
    check("wd_fault_ready", target_ready, 0);
    check("wd_fault_cmd", $signed(cmd), 0);
    enable = 1'b0;
    tick(1);
    check("wd_clear_state", state, 0);
    check("wd_clear_flag", wd_fault, 0);
    enable = 1'b1;

    // Periodic re-accepts keep the watchdog from firing.
    accept(50);
    for (int i = 0; i < 3; i++) begin
      tick(499);
      accept(50);
      check("keep_run", state, 1);
    end
    // Accept lands on the exact expiry cycle.
    tick(1000);
    check("exp_pre", state, 1);
    accept(50);
    check("exp_accept_wins", state, 1);
    tick(1);
    check("exp_after", state, 1);
    tick(999);
    check("exp_cleared", state, 1);
    tick(1);
    check("exp_restart_stop", state, 2);
    wait_state("exp_fault", 3, 400);
    enable = 1'b0;
    tick(1);
    check("exp_idle", state, 0);
    enable = 1'b1;

    // Reset mid-ramp at 24.
    accept(40);
    tick(15 + 16 * 5 + 1);
    check("mid_24", $signed(cmd), 24);
    reset = 1'b1;
    tick(1);
    check("mid_rst_cmd", $signed(cmd), 0);
    check("mid_rst_state", state, 0);
    check("mid_rst_fault", wd_fault, 0);
    check("mid_rst_at_target", at_target, 1);
    reset = 1'b0;

    // Large steps must saturate at the signed limits, never wrap.
    b_enable = 1'b1;
    b_reset  = 1'b0;
    tick(1);
    check("big_idle", b_state, 0);
    b_freq = 32'h7FFF_FFFF; b_valid = 1'b1;
    tick(1);
    b_valid = 1'b0;
    check("big_run", b_state, 1);
    check("big_c0", $signed(b_cmd), 0);
    tick(1);
    check("big_c1", $signed(b_cmd), 32'sh6000_0000);
    tick(1);
    check("big_max", $signed(b_cmd), 32'sh7FFF_FFFF);
    check("big_max_at", b_at_target, 1);
    b_freq = 32'h8000_0000; b_valid = 1'b1;
    tick(1);
    b_valid = 1'b0;
    check("big_hold_max", $signed(b_cmd), 32'sh7FFF_FFFF);
    tick(1);
    check("big_d1", $signed(b_cmd), 32'sh1FFF_FFFF);
    tick(1);
    check("big_zero", $signed(b_cmd), 0);
    tick(1);
    check("big_neg1", $signed(b_cmd), -64'sh6000_0000);
    tick(1);
    check("big_min", $signed(b_cmd), -64'sh8000_0000);
    check("big_min_at", b_at_target, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/joint_ramp_ctrl.md
Name: joint_ramp_ctrl

Overview:
- Velocity-command sequencer placed in front of one stepgen instance.
- Accepts target step-frequency commands over a valid/ready handshake and slews the stepgen's jointFreqCmd toward each target at a bounded acceleration.
- Forces a controlled ramp to zero on disable or on command-watchdog expiry, and latches a fault after a watchdog stop.

Parameters:
- WIDTH, 32: width of the signed frequency command.
- ACCEL_DIV, 16: clk cycles between ramp updates (minimum 1).
- ACCEL_STEP, 4: maximum change of jointFreqCmd per ramp update (unsigned, ≥1).
- WATCHDOG, 1000: clk cycles without an accepted command before a forced stop.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run permission. Low forces a ramp to zero; low also clears a fault.
- target_freq  in  WIDTH  signed target step frequency.
- target_valid  in  1  target_freq is valid.
- target_ready  out  1  controller accepts a target this cycle.
- jointFreqCmd  out  WIDTH  signed frequency command to stepgen.
- at_target  out  1  jointFreqCmd equals the effective target.
- wd_fault  out  1  watchdog stop has completed; fault is latched.
- state  out  2  0=IDLE, 1=RUN, 2=STOPPING, 3=FAULT.

Behaviour:
- All logic is clocked on clk. Reset is synchronous, active-high, and has priority over everything else.
- Reset values:
  - jointFreqCmd=0, tgt=0, state=IDLE
  - ramp counter=0, watchdog counter=0
  - wd_fault=0, target_ready=0, at_target=1
- Handshake:
  - target_ready = enable && (state==IDLE || state==RUN).
  - A target is accepted on target_valid && target_ready. It is latched into tgt and the watchdog counter is cleared in the same cycle.
  - A new accept overrides any ramp in progress. No queueing.
- Effective target = tgt in RUN; 0 in all other states.
- Ramp counter:
  - Counts 0..ACCEL_DIV-1 continuously, except in IDLE and FAULT where it is held at 0.
  - A ramp update occurs on the cycle it wraps to 0.
- Ramp update with e = effective target, f = jointFreqCmd:
  - f<e: f = min(f+ACCEL_STEP, e).
  - f>e: f = max(f-ACCEL_STEP, e).
  - Zero crossing: if f≠0 and the step result would have the opposite sign to f, f = 0 exactly. The next update continues from 0. This guarantees one ramp period at 0 before a direction reversal, giving stepgen DIR setup time.
  - Arithmetic is done in WIDTH+1 bits, then clamped to the signed WIDTH range. No wrap-around is permitted.
- at_target = (jointFreqCmd == effective target). It is combinational from registers.
- Watchdog:
  - Increments every cycle in RUN while jointFreqCmd≠0 or tgt≠0.
  - Cleared on accept and in every state other than RUN.
  - Saturates at WATCHDOG.
- State transitions:
  - IDLE→RUN: on an accept.
  - RUN→STOPPING: enable=0, or watchdog reaches WATCHDOG. The cause is recorded (wd_cause=1 for a watchdog stop).
  - RUN→IDLE: enable=1, tgt=0, jointFreqCmd=0, and no accept this cycle.
  - STOPPING→FAULT: jointFreqCmd=0 and wd_cause=1.
  - STOPPING→IDLE: jointFreqCmd=0 and wd_cause=0.
  - FAULT→IDLE: enable=0. wd_fault=0 from the next cycle.
- Outputs by state:
  - wd_fault=1 exactly while state==FAULT.
  - jointFreqCmd is held at 0 in IDLE and FAULT.
- Simultaneous events:
  - enable falling in the same cycle as target_valid: no accept, since ready is low; go to STOPPING.
  - Accept in the same cycle the watchdog would expire: the accept wins, the counter clears, and the state stays RUN.
- STOPPING ignores target_valid. Ramp-down continues even if enable returns high.
- Reset mid-ramp: jointFreqCmd=0 on the next cycle (abrupt stop is acceptable on reset only).

Test Plan:
- Reset, then enable=1 and accept target 40 (ACCEL_DIV=16, ACCEL_STEP=4): jointFreqCmd rises by 4 every 16 cycles, reaches 40 after 10 updates, then at_target=1 and state=RUN.
- At 40, accept −10: values step 36,32,…,4, then 0, then −4, −8, −10. The 0 is held for exactly one ramp period.
- Accept 10, then deassert enable: STOPPING, ramp to 0, then IDLE with target_ready=1. wd_fault stays 0 throughout.
- Accept 20, then no further commands for 1000 cycles: STOPPING, ramp to 0, then FAULT with wd_fault=1 and target_ready=0. A pulse enable=0 returns to IDLE.
- Hold target_valid with target 50 and re-accept every 500 cycles: no watchdog stop. Also check an accept landing on the exact expiry cycle keeps state=RUN.
- Assert reset while jointFreqCmd=24 mid-ramp: next cycle jointFreqCmd=0, state=IDLE, wd_fault=0. Also check that target 2^31−1 from near the limit clamps with no overflow.
